dmem_responder: RTL

- Data-memory responder for the CPU's load/store port: word-addressed RAM behind a valid/ready request channel and a valid/ready response channel.
- Sits between the datapath's memory outputs (address = ALU result, store data = register read data) and its load-data input.
- Takes the place of the ideal zero-latency memory, so the core can be tested against a realistic multi-cycle memory.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_array.sv | 32 +++
 rtl/dmem_responder.sv | 108 ++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, widths and the address-legality check for the data-memory responder.
package dmem_pkg;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misaligned or beyond the last word; index is compared unsigned, no wrap.
    function automatic logic addr_err(input logic [31:0] addr, input logic [31:0] depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
    endfunction
endpackage

// File: rtl/dmem_if.sv
// Load/store port: valid/ready request channel plus valid/ready response channel.
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [BE_W-1:0]   req_be;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with per-byte write enables; read data registered, 1 cycle.
// No flow control: the caller pulses i_en once per access and o_rdata holds until the next load.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = 10
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [AW-1:0]     i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [BE_W-1:0]   i_be,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (i_be[i]) begin
                        r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                    end
                end
            end else begin
                o_rdata <= r_mem[i_idx];
            end
        end
    end
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data memory for the core's load/store port; response LATENCY cycles after accept.
// One request outstanding; req_ready drops until the response handshake, response held while rsp_ready=0.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [31:0]       r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [BE_W-1:0]   r_be;
    logic              r_err;
    logic              r_load_ok;
    logic              w_accept;
    logic              w_commit;
    logic              w_err;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_accept = (r_state == IDLE) && bus.req_valid;
    // Reset on the commit edge must suppress the RAM write as well as the state change.
    assign w_commit = reset && (r_state == WAIT) && (r_cnt == '0);
    assign w_err    = addr_err(r_addr, 32'(DEPTH_WORDS));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid)   w_state_nxt = WAIT;
            WAIT:    if (r_cnt == '0)     w_state_nxt = RESP;
            RESP:    if (bus.rsp_ready)   w_state_nxt = IDLE;
            default:                      w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        case (r_state)
            IDLE: bus.req_ready = 1'b1;
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = r_err;
                bus.rsp_rdata = r_load_ok ? w_ram_rdata : '0;
            end
            default: ;
        endcase
    end

    // Counter reaches zero one edge before commit, so commit lands LATENCY edges after accept.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_load_ok <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= CNT_W'(LATENCY - 1);
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_commit) begin
                r_err     <= w_err;
                r_load_ok <= !r_we && !w_err;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= bus.req_we;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
            r_be    <= bus.req_be;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .i_en    (w_commit && !w_err),
        .i_we    (r_we),
        .i_idx   (r_addr[AW+1:2]),
        .i_wdata (r_wdata),
        .i_be    (r_be),
        .o_rdata (w_ram_rdata)
    );
endmodule
